// File: rtl/mem_load_unit.sv
// Load unit: runs MIPS loads over an Avalon-style read bus.
// Produces formatted, merged and flag results for writeback.
module mem_load_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        load_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rt_old,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic [3:0]        mem_byteenable,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       data_readdata,
    output logic [31:0]       lwlr_data,
    output logic              islwlr,
    output logic              done,
    output logic              busy,
    output logic              err_align
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  lat_type;
    logic [1:0]  lat_k;
    logic [31:0] lat_rt;

    logic        in_half;
    logic        in_word;
    logic        in_mis;
    logic [3:0]  in_be;

    logic        l_byte;
    logic        l_half;
    logic        l_lwl;
    logic        l_lwr;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] fmt_data;
    logic [31:0] fmt_lwlr;

    // Alignment check and lane selection for the incoming request.
    always_comb begin
        in_half = (load_type[1:0] == 2'b01);
        in_word = (load_type[1:0] == 2'b11);
        in_mis  = (in_half & addr[0]) |
                  (in_word & (addr[1:0] != 2'b00));
        in_be   = 4'b1111;
        unique case (1'b1)
            (load_type[1:0] == 2'b00): in_be = 4'b0001 << addr[1:0];
            in_half:                   in_be = 4'b0011 << addr[1:0];
            default:                   in_be = 4'b1111;
        endcase
    end

    // Extract, extend and merge the returned word for the latched load.
    always_comb begin
        l_byte = (lat_type[1:0] == 2'b00);
        l_half = (lat_type[1:0] == 2'b01);
        l_lwl  = (lat_type == 3'b010);
        l_lwr  = (lat_type == 3'b110);

        unique case (lat_k)
            2'd0:    sel_b = mem_readdata[7:0];
            2'd1:    sel_b = mem_readdata[15:8];
            2'd2:    sel_b = mem_readdata[23:16];
            default: sel_b = mem_readdata[31:24];
        endcase
        sel_h = lat_k[1] ? mem_readdata[31:16] : mem_readdata[15:0];

        fmt_data = mem_readdata;
        unique case (1'b1)
            l_byte:  fmt_data = {{24{sel_b[7] & ~lat_type[2]}}, sel_b};
            l_half:  fmt_data = {{16{sel_h[15] & ~lat_type[2]}}, sel_h};
            default: fmt_data = mem_readdata;
        endcase

        fmt_lwlr = 32'd0;
        if (l_lwl) begin
            unique case (lat_k)
                2'd0:    fmt_lwlr = {mem_readdata[7:0], lat_rt[23:0]};
                2'd1:    fmt_lwlr = {mem_readdata[15:0], lat_rt[15:0]};
                2'd2:    fmt_lwlr = {mem_readdata[23:0], lat_rt[7:0]};
                default: fmt_lwlr = mem_readdata;
            endcase
        end else if (l_lwr) begin
            unique case (lat_k)
                2'd0:    fmt_lwlr = mem_readdata;
                2'd1:    fmt_lwlr = {lat_rt[31:24], mem_readdata[31:8]};
                2'd2:    fmt_lwlr = {lat_rt[31:16], mem_readdata[31:16]};
                default: fmt_lwlr = {lat_rt[31:8], mem_readdata[31:24]};
            endcase
        end
    end

    // Control FSM with registered bus and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            lat_type       <= 3'd0;
            lat_k          <= 2'd0;
            lat_rt         <= 32'd0;
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_byteenable <= 4'd0;
            data_readdata  <= 32'd0;
            lwlr_data      <= 32'd0;
            islwlr         <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            err_align      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lat_type <= load_type;
                        lat_k    <= addr[1:0];
                        lat_rt   <= rt_old;
                        busy     <= 1'b1;
                        if (in_mis) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            err_align     <= 1'b1;
                            data_readdata <= 32'd0;
                            lwlr_data     <= 32'd0;
                            islwlr        <= 1'b0;
                        end else begin
                            state          <= REQ;
                            mem_read       <= 1'b1;
                            mem_address    <= {addr[ADDR_W-1:2], 2'b00};
                            mem_byteenable <= in_be;
                        end
                    end
                end
                REQ: begin
                    if (!mem_waitrequest) begin
                        state         <= DONE;
                        mem_read      <= 1'b0;
                        done          <= 1'b1;
                        err_align     <= 1'b0;
                        data_readdata <= fmt_data;
                        lwlr_data     <= fmt_lwlr;
                        islwlr        <= l_lwl | l_lwr;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mem_read <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Testbench for mem_load_unit: directed cases then random loads
// checked against an arithmetic reference model.
module tb_mem_load_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  load_type;
    logic [31:0] addr;
    logic [31:0] rt_old;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [31:0] data_readdata;
    logic [31:0] lwlr_data;
    logic        islwlr;
    logic        done;
    logic        busy;
    logic        err_align;

    int checks = 0;
    int errors = 0;

    mem_load_unit #(.ADDR_W(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .load_type       (load_type),
        .addr            (addr),
        .rt_old          (rt_old),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_byteenable  (mem_byteenable),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .data_readdata   (data_readdata),
        .lwlr_data       (lwlr_data),
        .islwlr          (islwlr),
        .done            (done),
        .busy            (busy),
        .err_align       (err_align)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: results computed directly from the load rules.
    function automatic void ref_model(
        input  logic [2:0]  t,
        input  logic [31:0] a,
        input  logic [31:0] rt,
        input  logic [31:0] w,
        output logic [31:0] data,
        output logic [31:0] lwlr,
        output logic        isl,
        output logic        err,
        output logic [3:0]  be
    );
        int unsigned k;
        logic [31:0] b;
        logic [31:0] h;
        logic [63:0] m;
        k    = a % 4;
        data = w;
        lwlr = 32'd0;
        isl  = 1'b0;
        err  = 1'b0;
        be   = 4'hF;
        b    = (w >> (8 * k)) & 32'hFF;
        h    = (w >> (8 * k)) & 32'hFFFF;
        case (t)
            3'b000: begin data = (b >= 128) ? b + 32'hFFFFFF00 : b;
                          be = 4'(1 << k); end
            3'b100: begin data = b; be = 4'(1 << k); end
            3'b001: begin data = (h >= 32768) ? h + 32'hFFFF0000 : h;
                          be = 4'(3 << k); err = (k % 2) != 0; end
            3'b101: begin data = h; be = 4'(3 << k);
                          err = (k % 2) != 0; end
            3'b010: begin
                m    = 64'hFFFFFFFF >> (8 * (k + 1));
                lwlr = (w << (8 * (3 - k))) | (rt & m[31:0]);
                isl  = 1'b1;
            end
            3'b110: begin
                m    = 64'hFFFFFFFF >> (8 * k);
                lwlr = (w >> (8 * k)) | (rt & ~m[31:0]);
                isl  = 1'b1;
            end
            default: err = (k != 0);
        endcase
        if (err) begin
            data = 32'd0;
            lwlr = 32'd0;
        end
    endfunction

    // Issue one load and follow it cycle by cycle to completion.
    task automatic run_load(input logic [2:0] t, input logic [31:0] a,
                            input logic [31:0] rt, input logic [31:0] w,
                            input int waits, input bit poke);
        logic [31:0] e_data, e_lwlr;
        logic e_isl, e_err;
        logic [3:0] e_be;
        int cyc;
        int done_cyc;
        int exp_cyc;
        logic exp_read;
        ref_model(t, a, rt, w, e_data, e_lwlr, e_isl, e_err, e_be);
        exp_cyc = e_err ? 1 : 2 + waits;
        @(negedge clk);
        start = 1'b1;
        load_type = t;
        addr = a;
        rt_old = rt;
        mem_readdata = w;
        mem_waitrequest = (waits > 0);
        @(negedge clk);
        start = 1'b0;
        load_type = 3'($urandom);
        addr = $urandom;
        rt_old = $urandom;
        cyc = 1;
        done_cyc = 0;
        while (cyc < 40) begin
            exp_read = !e_err && (cyc <= waits + 1);
            chk("mem_read", {31'd0, mem_read}, {31'd0, exp_read});
            if (exp_read) begin
                chk("mem_address", mem_address, {a[31:2], 2'b00});
                chk("byteenable", {28'd0, mem_byteenable}, {28'd0, e_be});
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            chk("busy", {31'd0, busy}, 32'd1);
            mem_waitrequest = (cyc <= waits);
            start = poke && mem_read;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        mem_waitrequest = 1'b0;
        chk("done_cycle", done_cyc, exp_cyc);
        chk("err_align", {31'd0, err_align}, {31'd0, e_err});
        chk("islwlr", {31'd0, islwlr}, {31'd0, e_isl});
        chk("data_readdata", data_readdata, e_data);
        if (e_isl) chk("lwlr_data", lwlr_data, e_lwlr);
        mem_readdata = $urandom;
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("data_hold", data_readdata, e_data);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        load_type = 3'd0;
        addr = 32'd0;
        rt_old = 32'd0;
        mem_waitrequest = 1'b0;
        mem_readdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_read", {31'd0, mem_read}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", data_readdata, 32'd0);
        reset_n = 1'b1;

        run_load(3'b011, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        run_load(3'b000, 32'h1003, 32'h0, 32'h85000000, 0, 1'b0);
        run_load(3'b100, 32'h1003, 32'h0, 32'h85000000, 0, 1'b0);
        run_load(3'b101, 32'h1002, 32'h0, 32'h85000000, 0, 1'b0);
        run_load(3'b010, 32'h2001, 32'h11223344, 32'hAABBCCDD, 0, 1'b0);
        run_load(3'b110, 32'h2001, 32'h11223344, 32'hAABBCCDD, 0, 1'b0);
        run_load(3'b011, 32'h400, 32'h0, 32'h12345678, 3, 1'b1);
        run_load(3'b001, 32'h3001, 32'h0, 32'h0, 0, 1'b0);
        run_load(3'b001, 32'h3002, 32'h0, 32'h80010000, 1, 1'b0);
        run_load(3'b111, 32'h3002, 32'h0, 32'h0, 0, 1'b0);
        run_load(3'b111, 32'h3004, 32'h0, 32'hCAFEF00D, 0, 1'b0);
        run_load(3'b010, 32'h2003, 32'h11223344, 32'hAABBCCDD, 0, 1'b0);
        run_load(3'b110, 32'h2000, 32'h11223344, 32'hAABBCCDD, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            run_load(3'($urandom), $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 3)), 1'($urandom));
        end

        @(negedge clk);
        start = 1'b1;
        load_type = 3'b011;
        addr = 32'h40;
        mem_waitrequest = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst_read", {31'd0, mem_read}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_read", {31'd0, mem_read}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_waitrequest = 1'b0;
        @(negedge clk);
        chk("post_rst_addr", mem_address, 32'd0);
        chk("post_rst_be", {28'd0, mem_byteenable}, 32'd0);
        chk("post_rst_data", data_readdata, 32'd0);
        chk("post_rst_lwlr", lwlr_data, 32'd0);
        chk("post_rst_isl", {31'd0, islwlr}, 32'd0);
        chk("post_rst_err", {31'd0, err_align}, 32'd0);
        chk("post_rst_read", {31'd0, mem_read}, 32'd0);
        run_load(3'b011, 32'h80, 32'h0, 32'h0BADCAFE, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
